// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed multi-digit 7-segment driver for the garage occupancy and
//   free-space counters. A binary value captured on a load strobe is converted
//   to BCD one bit per clock (shift-add-3). The display register is updated in
//   one step when the conversion finishes. DIGITS common-anode digits are
//   scanned through a shared active-low segment bus. Extra features: overflow
//   dashes, blanking, and optional leading-zero suppression.
//
//   Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//     When it is defined, a digit above the most significant non-zero digit
//     stays dark during its slot. Digit 0 is always shown, and suppression is
//     disabled while the overflow dashes are displayed.
//
// Ports
//   clk    in   1        single clock, rising edge
//   rst_n  in   1        asynchronous active-low reset
//   value  in   VALUE_W  unsigned binary to display, sampled on accepted load
//   load   in   1        one-cycle capture strobe
//   blank  in   1        level, forces the display dark while high
//   seg_n  out  7        segments a..g at bits 6..0, active-low
//   dig_n  out  DIGITS   one-hot digit enables, active-low, bit 0 = LS digit
//   busy   out  1        conversion in progress
//   ovf    out  1        displayed value exceeds 10^DIGITS-1
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS  = 2,
  parameter int VALUE_W = 7,
  parameter int CLK_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank,
  output logic [6:0]         seg_n,
  output logic [DIGITS-1:0]  dig_n,
  output logic               busy,
  output logic               ovf
);

  // BCD digits needed for 2^VALUE_W-1 is floor(VALUE_W*log10(2))+1. The
  // register is never narrower than DIGITS, so the overflow compare sees the
  // full value.
  localparam int BCD_MIN = (VALUE_W * 30103) / 100000 + 1;
  localparam int BCD_N   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int SH_W    = BCD_W + VALUE_W;
  localparam int DISP_W  = 4 * DIGITS;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int PS_W    = $clog2(CLK_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] MAX_DISP = 32'(10 ** DIGITS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SH_W-1:0]    r_sh;
  logic               r_ovf_next;
  logic               r_pend_vld;
  logic [VALUE_W-1:0] r_pend_val;
  logic [DISP_W-1:0]  r_disp;
  logic               r_ovf;
  logic [PS_W-1:0]    r_presc;
  logic [IDX_W-1:0]   r_idx;
  logic [6:0]         r_seg;
  logic [DIGITS-1:0]  r_dig;

  logic               w_start;
  logic [VALUE_W-1:0] w_start_val;
  logic [3:0]         w_nib;
  logic [DIGITS-1:0]  w_dig_sel;
  logic [DIGITS-1:0]  w_show;

  // Adds 3 to every BCD nibble that is >= 5 (pre-correction before a shift).
  function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (res[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

  // One double-dabble iteration: the BCD part is corrected, then the whole
  // {bcd, binary} register shifts left by one bit.
  function automatic logic [SH_W-1:0] f_step(input logic [SH_W-1:0] sh);
    logic [SH_W-1:0] tmp;
    tmp = {f_add3(sh[SH_W-1:VALUE_W]), sh[VALUE_W-1:0]};
    return {tmp[SH_W-2:0], 1'b0};
  endfunction

  function automatic logic f_ovf(input logic [VALUE_W-1:0] v);
    return ({{(32-VALUE_W){1'b0}}, v} > MAX_DISP);
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // A conversion starts from IDLE on a load. It also starts straight out of
  // COMMIT when a load arrives in that cycle or one is pending. A load in the
  // same cycle is newer than the pending value, so it takes priority.
  always_comb begin
    w_start     = 1'b0;
    w_start_val = value;
    if (r_state == S_IDLE) begin
      w_start = load;
    end else if (r_state == S_COMMIT) begin
      w_start     = load | r_pend_vld;
      w_start_val = load ? value : r_pend_val;
    end
  end

  // Conversion datapath: no reset is needed because r_sh and r_ovf_next are
  // always written at the start of a conversion before they are read.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_sh       <= {{BCD_W{1'b0}}, w_start_val};
      r_ovf_next <= f_ovf(w_start_val);
    end else if (r_state == S_SHIFT) begin
      r_sh <= f_step(r_sh);
    end
    if (load && (r_state != S_IDLE)) r_pend_val <= value;
  end

  // Select the nibble and the one-hot digit enable for the current scan index.
  always_comb begin
    w_nib     = 4'd0;
    w_dig_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib        = r_disp[i*4 +: 4];
        w_dig_sel[i] = 1'b0;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Scan from the MS digit downward. A digit is shown once any digit at or
  // above it is non-zero.
  always_comb begin
    logic nz;
    nz     = 1'b0;
    w_show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz        = nz | (r_disp[i*4 +: 4] != 4'd0);
      w_show[i] = nz | (i == 0) | r_ovf;
    end
  end
`else
  assign w_show = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
      r_presc    <= '0;
      r_idx      <= '0;
      r_seg      <= 7'b1111111;
      r_dig      <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(VALUE_W - 1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_disp <= r_sh[VALUE_W +: DISP_W];
          r_ovf  <= r_ovf_next;
          if (w_start) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A load in COMMIT is used directly. A load in SHIFT is kept for later,
      // and a newer one replaces an older one.
      if (r_state == S_COMMIT) r_pend_vld <= 1'b0;
      else if (load && (r_state != S_IDLE)) r_pend_vld <= 1'b1;

      // Scan prescaler and digit index run freely, whatever busy and blank are.
      if (r_presc == PS_W'(CLK_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (blank) begin
        r_seg <= 7'b1111111;
        r_dig <= '1;
      end else begin
        r_seg <= r_ovf ? 7'b1111110 : f_seg(w_nib);
        r_dig <= w_dig_sel | ~w_show;
      end
    end
  end

  assign seg_n = r_seg;
  assign dig_n = r_dig;
  assign busy  = (r_state != S_IDLE);
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic [6:0] value;
  logic       load;
  logic       blank;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  logic       busy;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int cnt;

  seg7_scan_driver #(.DIGITS(2), .VALUE_W(7), .CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .blank (blank),
    .seg_n (seg_n),
    .dig_n (dig_n),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release. After edge k the digit slot is
  // ((k-1)/4)%2, because the registered outputs lag the index by one clock.
  always @(posedge clk) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_chk(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                          input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      step();
      d = ((ncyc - 1) / 4) % 2;
      chk({tag, "_dig"}, 32'(dig_n), (d == 1) ? 32'h1 : 32'h2);
      chk({tag, "_seg"}, 32'(seg_n), 32'((d == 1) ? s1 : s0));
    end
  endtask

  task automatic load_val(input logic [6:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    blank = 1'b0;

    // Reset state
    step();
    chk("rst_seg",  32'(seg_n), 32'(SEG_OFF));
    chk("rst_dig",  32'(dig_n), 32'h3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf",  32'(ovf), 32'h0);
    step();
    rst_n = 1'b1;

    // First edge after release shows digit 0 as "0"; then the idle scan runs
    step();
    chk("first_dig", 32'(dig_n), 32'h2);
    chk("first_seg", 32'(seg_n), 32'(SEG_0));
    scan_chk("idle", SEG_0, SEG_0, 8);

    // 47: busy for VALUE_W+1 = 8 cycles, then shows "47"
    load_val(7'd47);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step();
    end
    chk("v47_busy_len", 32'(cnt), 32'd8);
    chk("v47_ovf", 32'(ovf), 32'h0);
    scan_chk("v47", SEG_7, SEG_4, 8);

    // 127 exceeds 99: dashes on both digits
    load_val(7'd127);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step();
    end
    chk("v127_busy_len", 32'(cnt), 32'd8);
    chk("v127_ovf", 32'(ovf), 32'h1);
    scan_chk("v127", SEG_DASH, SEG_DASH, 8);

    // 23, then 58 three cycles later. 58 waits as the pending load, so busy
    // stays high across both conversions (2 x 8 cycles).
    load_val(7'd23);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 3) begin
        value = 7'd58;
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      step();
    end
    load = 1'b0;
    chk("chain_busy_len", 32'(cnt), 32'd16);
    chk("chain_ovf", 32'(ovf), 32'h0);
    scan_chk("v58", SEG_8, SEG_5, 16);
    chk("v58_idle", 32'(busy), 32'h0);

    // Blank for 10 cycles; the scan phase must be unchanged afterwards
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("blank_seg", 32'(seg_n), 32'(SEG_OFF));
      chk("blank_dig", 32'(dig_n), 32'h3);
    end
    blank = 1'b0;
    scan_chk("unblank", SEG_8, SEG_5, 8);

    // Asynchronous reset in the middle of SHIFT
    load_val(7'd47);
    step();
    step();
    chk("midshift_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_seg",  32'(seg_n), 32'(SEG_OFF));
    chk("arst_dig",  32'(dig_n), 32'h3);
    chk("arst_ovf",  32'(ovf), 32'h0);
    step();
    rst_n = 1'b1;
    scan_chk("post_rst", SEG_0, SEG_0, 8);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_ovf",  32'(ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
